port_in: RTL and testbench

- Input-direction companion to the processor's output GPIO port.
- Samples WIDTH external pins, synchronises each bit to clk, debounces each bit independently, and presents a stable value to the CPU read path.
- Detects rising and/or falling edges per bit into sticky, write-1-to-clear flags, which drive one level interrupt request to the core.

---
 rtl/port_pkg.sv | 10 +
 rtl/port_debounce_bit.sv | 35 +++
 rtl/port_in.sv | 50 +++++
 tb/tb_port_in.sv | 135 +++++++++++++
 4 files changed

// File: rtl/port_pkg.sv
// port_pkg: shared constants, word type and sizing helper for the GPIO port blocks
package port_pkg;
   localparam int PORT_WIDTH = 8;
   localparam int PORT_SYNC_STAGES = 2;
   localparam int PORT_DEBOUNCE_CYCLES = 4;
   typedef logic [PORT_WIDTH-1:0] port_word_t;
   function automatic int cnt_bits(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction
endpackage

// File: rtl/port_debounce_bit.sv
// port_debounce_bit: one pin's synchroniser, debounce counter, stable flop and edge pulses
module port_debounce_bit import port_pkg::*; #(
   parameter int SYNC_STAGES = PORT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = PORT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic stable,
   output logic rise,
   output logic fall
);
   localparam int cnt_w = cnt_bits(DEBOUNCE_CYCLES);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync;
   logic [cnt_w-1:0] cnt;
   logic syncd, differ, done;
   assign syncd = sync[SYNC_STAGES-1];
   assign differ = syncd ^ stable;
   // done marks the cycle stable takes the new level; edge pulses align with it
   assign done = differ && (cnt == cnt_last);
   assign rise = done & syncd;
   assign fall = done & ~syncd;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         cnt <= '0;
         stable <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin};
         cnt <= (differ && !done) ? cnt + 1'b1 : '0;
         stable <= done ? syncd : stable;
      end
   end
endmodule

// File: rtl/port_in.sv
// port_in: debounced GPIO input port with sticky write-1-to-clear edge flags and irq
module port_in import port_pkg::*; #(
   parameter int WIDTH = PORT_WIDTH,
   parameter int SYNC_STAGES = PORT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = PORT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin,
   input  logic             ceRiseEn,
   input  logic             ceFallEn,
   input  logic [WIDTH-1:0] cfgData,
   input  logic             ceFlagClr,
   output logic [WIDTH-1:0] rdData,
   output logic [WIDTH-1:0] flags,
   output logic             irq
);
   logic [WIDTH-1:0] rise, fall, rise_en, fall_en, set, clr;
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         port_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_bit (
            .clk(clk),
            .rst(rst),
            .pin(pin[i]),
            .stable(rdData[i]),
            .rise(rise[i]),
            .fall(fall[i])
         );
      end
   endgenerate
   assign set = (rise & rise_en) | (fall & fall_en);
   assign clr = ceFlagClr ? cfgData : '0;
   assign irq = |flags;
   // set is ORed after the clear mask so a same-cycle set survives its clear
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_en <= '0;
         fall_en <= '0;
         flags <= '0;
      end else begin
         if (ceRiseEn) rise_en <= cfgData;
         if (ceFallEn) fall_en <= cfgData;
         flags <= (flags & ~clr) | set;
      end
   end
endmodule

// File: tb/tb_port_in.sv
// tb_port_in: scoreboard bench; expectations are queued with their due cycle and checked at negedge
module tb_port_in;
   logic clk = 1'b0;
   logic rst;
   logic [7:0] pin;
   logic ceRiseEn, ceFallEn, ceFlagClr;
   logic [7:0] cfgData;
   logic [7:0] rdData, flags;
   logic irq;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   typedef struct {
      int cyc;
      logic [7:0] rd;
      logic [7:0] fl;
      string tag;
   } exp_t;
   exp_t sb[$];

   port_in dut (
      .clk(clk), .rst(rst), .pin(pin),
      .ceRiseEn(ceRiseEn), .ceFallEn(ceFallEn),
      .cfgData(cfgData), .ceFlagClr(ceFlagClr),
      .rdData(rdData), .flags(flags), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic expect_at(input int dly, input logic [7:0] rd, input logic [7:0] fl, input string tag);
      exp_t e;
      e.cyc = cyc + dly;
      e.rd = rd;
      e.fl = fl;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            chk({sb[i].tag, ".rd"}, 32'(rdData), 32'(sb[i].rd));
            chk({sb[i].tag, ".fl"}, 32'(flags), 32'(sb[i].fl));
            chk({sb[i].tag, ".irq"}, 32'(irq), 32'(|sb[i].fl));
            sb.delete(i);
         end
      end
   end

   initial begin
      rst = 1'b1; pin = 8'hFF; ceRiseEn = 1'b0; ceFallEn = 1'b0; ceFlagClr = 1'b0; cfgData = 8'h00;
      expect_at(1, 8'h00, 8'h00, "rst1");
      expect_at(2, 8'h00, 8'h00, "rst2");
      step(3);
      rst = 1'b0;
      expect_at(5, 8'h00, 8'h00, "hi_pre");
      expect_at(6, 8'hFF, 8'h00, "hi_rdy");
      step(8);
      pin = 8'h00;
      expect_at(6, 8'h00, 8'h00, "to_zero");
      step(8);
      pin = 8'h01;
      expect_at(5, 8'h00, 8'h00, "lat_pre");
      expect_at(6, 8'h01, 8'h00, "lat_rdy");
      step(8);
      for (int d = 1; d <= 10; d++) expect_at(d, 8'h01, 8'h00, "glitch");
      pin = 8'h09;
      step(3);
      pin = 8'h01;
      step(7);
      pin = 8'h00;
      expect_at(6, 8'h00, 8'h00, "back0");
      step(8);
      cfgData = 8'h0F; ceRiseEn = 1'b1;
      step(1);
      ceRiseEn = 1'b0; cfgData = 8'hF0; ceFallEn = 1'b1;
      step(1);
      ceFallEn = 1'b0; cfgData = 8'h00;
      pin = 8'h81;
      expect_at(5, 8'h00, 8'h00, "rise_pre");
      expect_at(6, 8'h81, 8'h01, "rise");
      step(8);
      pin = 8'h00;
      expect_at(5, 8'h81, 8'h01, "fall_pre");
      expect_at(6, 8'h00, 8'h81, "fall");
      step(8);
      cfgData = 8'h01; ceFlagClr = 1'b1;
      step(1);
      ceFlagClr = 1'b0;
      expect_at(0, 8'h00, 8'h80, "clr0");
      pin = 8'h01;
      expect_at(6, 8'h01, 8'h81, "set_wins");
      expect_at(7, 8'h01, 8'h81, "set_hold");
      step(5);
      ceFlagClr = 1'b1; cfgData = 8'h01;
      step(1);
      ceFlagClr = 1'b0;
      step(2);
      cfgData = 8'hFF; ceFlagClr = 1'b1;
      step(1);
      ceFlagClr = 1'b0; cfgData = 8'h00;
      expect_at(0, 8'h01, 8'h00, "clr_all");
      pin = 8'h05;
      expect_at(6, 8'h05, 8'h04, "b2_rise");
      step(8);
      pin = 8'h01;
      expect_at(4, 8'h05, 8'h04, "mid_cnt");
      step(4);
      rst = 1'b1;
      expect_at(1, 8'h00, 8'h00, "mid_rst");
      step(1);
      rst = 1'b0;
      expect_at(5, 8'h00, 8'h00, "rel_pre");
      expect_at(6, 8'h01, 8'h00, "rel_rdy");
      step(8);
      for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
      if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
